// File: rtl/round_controller.sv
// Round sequencer: vsync-derived frame/second ticks step IDLE -> COUNTDOWN -> PLAY -> TIMEOUT -> RESULT.
// Optional feature macro ROUND_CTRL_PAUSE_EN adds a pause input that freezes countdown/play timing.
module round_controller #(
  parameter int FRAMES_PER_SEC    = 60,
  parameter int COUNTDOWN_SECONDS = 3,
  parameter int GAME_SECONDS      = 60,
  parameter int RESULT_SECONDS    = 5,
  parameter int RESPAWN_FRAMES    = 30
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       vsync_in,
  input  logic       start,
`ifdef ROUND_CTRL_PAUSE_EN
  input  logic       pause,
`endif
  input  logic       grem0_alive,
  input  logic       grem1_alive,
  input  logic [7:0] points0,
  input  logic [7:0] points1,
  output logic       collision_rst_n,
  output logic       time_out,
  output logic       car0_enable,
  output logic       car1_enable,
  output logic       grem0_spawn,
  output logic       grem1_spawn,
  output logic [7:0] seconds_left,
  output logic [1:0] winner,
  output logic [2:0] state_out
);
  localparam int FW = $clog2(FRAMES_PER_SEC + 1);
  localparam int RW = $clog2(RESPAWN_FRAMES + 1);

  typedef enum logic [2:0] {
    IDLE = 3'd0, COUNTDOWN = 3'd1, PLAY = 3'd2, TIMEOUT = 3'd3, RESULT = 3'd4
  } state_t;

  state_t        state;
  logic          vsync_d, start_low, alive0_d, alive1_d;
  logic [FW-1:0] frame_cnt;
  logic [RW-1:0] resp0, resp1;
  logic          pause_i, timed, frame_tick, sec_tick, start_edge, kill0, kill1, last_sec, leave;

`ifdef ROUND_CTRL_PAUSE_EN
  assign pause_i = pause;
`else
  assign pause_i = 1'b0;
`endif

  assign state_out  = state;
  assign timed      = (state == COUNTDOWN) || (state == PLAY);
  assign frame_tick = vsync_in & ~vsync_d & ~(pause_i & timed);
  assign sec_tick   = frame_tick && (frame_cnt == FW'(FRAMES_PER_SEC - 1));
  // start_low is 0 out of reset, so a button held through reset must be released first.
  assign start_edge = start & start_low;
  assign kill0      = alive0_d & ~grem0_alive;
  assign kill1      = alive1_d & ~grem1_alive;
  assign last_sec   = sec_tick && (seconds_left == 8'd1);

  always_comb begin
    leave = 1'b0;
    case (state)
      IDLE:                    leave = start_edge;
      COUNTDOWN, PLAY, RESULT: leave = last_sec;
      default:                 leave = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= IDLE;
      vsync_d         <= 1'b0;
      start_low       <= 1'b0;
      alive0_d        <= 1'b0;
      alive1_d        <= 1'b0;
      frame_cnt       <= '0;
      resp0           <= '0;
      resp1           <= '0;
      collision_rst_n <= 1'b1;
      time_out        <= 1'b1;
      car0_enable     <= 1'b0;
      car1_enable     <= 1'b0;
      grem0_spawn     <= 1'b0;
      grem1_spawn     <= 1'b0;
      seconds_left    <= 8'(GAME_SECONDS);
      winner          <= 2'b00;
    end else begin
      vsync_d         <= vsync_in;
      start_low       <= ~start;
      alive0_d        <= grem0_alive;
      alive1_d        <= grem1_alive;
      collision_rst_n <= 1'b1;
      grem0_spawn     <= 1'b0;
      grem1_spawn     <= 1'b0;

      if (leave)
        frame_cnt <= '0;
      else if (frame_tick)
        frame_cnt <= (frame_cnt == FW'(FRAMES_PER_SEC - 1)) ? '0 : frame_cnt + 1'b1;

      // Respawn timers only run inside PLAY; a kill edge reloads ahead of any decrement.
      if (state != PLAY || leave)
        resp0 <= '0;
      else if (kill0)
        resp0 <= RW'(RESPAWN_FRAMES);
      else if (frame_tick && resp0 != '0) begin
        resp0       <= resp0 - 1'b1;
        grem0_spawn <= (resp0 == RW'(1));
      end

      if (state != PLAY || leave)
        resp1 <= '0;
      else if (kill1)
        resp1 <= RW'(RESPAWN_FRAMES);
      else if (frame_tick && resp1 != '0) begin
        resp1       <= resp1 - 1'b1;
        grem1_spawn <= (resp1 == RW'(1));
      end

      case (state)
        IDLE: begin
          time_out    <= 1'b1;
          car0_enable <= 1'b0;
          car1_enable <= 1'b0;
          if (start_edge) begin
            state           <= COUNTDOWN;
            seconds_left    <= 8'(COUNTDOWN_SECONDS);
            collision_rst_n <= 1'b0;
          end
        end
        COUNTDOWN: begin
          time_out    <= 1'b1;
          car0_enable <= 1'b0;
          car1_enable <= 1'b0;
          if (last_sec) begin
            state        <= PLAY;
            seconds_left <= 8'(GAME_SECONDS);
            time_out     <= 1'b0;
            car0_enable  <= 1'b1;
            car1_enable  <= 1'b1;
            grem0_spawn  <= 1'b1;
            grem1_spawn  <= 1'b1;
          end else if (sec_tick)
            seconds_left <= seconds_left - 8'd1;
        end
        PLAY: begin
          time_out    <= pause_i;
          car0_enable <= ~pause_i;
          car1_enable <= ~pause_i;
          if (last_sec) begin
            state        <= TIMEOUT;
            seconds_left <= 8'd0;
            time_out     <= 1'b1;
            car0_enable  <= 1'b0;
            car1_enable  <= 1'b0;
          end else if (sec_tick)
            seconds_left <= seconds_left - 8'd1;
        end
        TIMEOUT: begin
          time_out     <= 1'b1;
          car0_enable  <= 1'b0;
          car1_enable  <= 1'b0;
          state        <= RESULT;
          seconds_left <= 8'(RESULT_SECONDS);
          winner       <= (points0 > points1) ? 2'b01 : (points0 < points1) ? 2'b10 : 2'b11;
        end
        RESULT: begin
          time_out    <= 1'b1;
          car0_enable <= 1'b0;
          car1_enable <= 1'b0;
          if (last_sec) begin
            state        <= IDLE;
            winner       <= 2'b00;
            seconds_left <= 8'(GAME_SECONDS);
          end else if (sec_tick)
            seconds_left <= seconds_left - 8'd1;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_round_controller.sv
// Bench for round_controller: randomized rounds scored against a frame-schedule reference model.
module tb_round_controller;
  localparam int FPS  = 2;
  localparam int CD   = 2;
  localparam int G    = 3;
  localparam int R    = 1;
  localparam int RESP = 2;

  typedef struct packed {
    logic [2:0] st;
    logic [7:0] sl;
    logic [1:0] win;
    logic       to, c0, c1, clr_n, sp0, sp1;
  } snap_t;

  typedef struct {
    snap_t s;
    int    f;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst, vsync_in, start, grem0_alive, grem1_alive;
  logic [7:0] points0, points1;
`ifdef ROUND_CTRL_PAUSE_EN
  logic       pause;
`endif
  logic       collision_rst_n, time_out, car0_enable, car1_enable, grem0_spawn, grem1_spawn;
  logic [7:0] seconds_left;
  logic [1:0] winner;
  logic [2:0] state_out;

  int    checks = 0, failures = 0, frame_no = 0;
  exp_t  exp_q[$];
  snap_t m, last_pushed;
  int    phase = 0, pf = 0, due0 = -1, due1 = -1;
  bit    pz = 1'b0;

  round_controller #(.FRAMES_PER_SEC(FPS), .COUNTDOWN_SECONDS(CD), .GAME_SECONDS(G),
                     .RESULT_SECONDS(R), .RESPAWN_FRAMES(RESP)) dut (
    .clk(clk), .rst(rst), .vsync_in(vsync_in), .start(start),
`ifdef ROUND_CTRL_PAUSE_EN
    .pause(pause),
`endif
    .grem0_alive(grem0_alive), .grem1_alive(grem1_alive),
    .points0(points0), .points1(points1),
    .collision_rst_n(collision_rst_n), .time_out(time_out),
    .car0_enable(car0_enable), .car1_enable(car1_enable),
    .grem0_spawn(grem0_spawn), .grem1_spawn(grem1_spawn),
    .seconds_left(seconds_left), .winner(winner), .state_out(state_out));

  always #5 clk = ~clk;

  function automatic snap_t rst_snap();
    snap_t s;
    s = '{st: 3'd0, sl: 8'(G), win: 2'd0, to: 1'b1, c0: 1'b0, c1: 1'b0,
          clr_n: 1'b1, sp0: 1'b0, sp1: 1'b0};
    return s;
  endfunction

  function automatic snap_t dut_snap();
    snap_t s;
    s = {state_out, seconds_left, winner, time_out, car0_enable, car1_enable,
         collision_rst_n, grem0_spawn, grem1_spawn};
    return s;
  endfunction

  // Only visible output changes are queued; identical consecutive snapshots collapse.
  function automatic void push();
    exp_t e;
    if (m !== last_pushed) begin
      e.s = m;
      e.f = frame_no;
      exp_q.push_back(e);
      last_pushed = m;
    end
  endfunction

  function automatic void model_start();
    if (phase == 0) begin
      phase = 1; pf = 0; due0 = -1; due1 = -1;
      m.st = 3'd1; m.sl = 8'(CD); m.clr_n = 1'b0; push();
      m.clr_n = 1'b1; push();
    end
  endfunction

  function automatic void model_kill(input int i);
    if (phase == 2) begin
      if (i == 0) due0 = pf + RESP;
      else        due1 = pf + RESP;
    end
  endfunction

  function automatic void model_reset();
    m = rst_snap();
    phase = 0; pf = 0; due0 = -1; due1 = -1; pz = 1'b0;
    push();
  endfunction

  // One vsync rising edge: pf counts unpaused frames since the current phase began.
  function automatic void model_frame(input bit k0, input bit k1);
    int ph0;
    bit s0, s1;
    ph0 = phase;
    if (phase == 1 && !pz) begin
      pf++;
      if (pf == FPS * CD) begin
        phase = 2; pf = 0;
        m.st = 3'd2; m.sl = 8'(G); m.to = 1'b0; m.c0 = 1'b1; m.c1 = 1'b1;
        m.sp0 = 1'b1; m.sp1 = 1'b1; push();
        m.sp0 = 1'b0; m.sp1 = 1'b0; push();
      end else if (pf % FPS == 0) begin
        m.sl = 8'(CD - pf / FPS); push();
      end
    end else if (phase == 2 && !pz) begin
      pf++;
      if (pf == FPS * G) begin
        phase = 3; pf = 0; due0 = -1; due1 = -1;
        m.st = 3'd3; m.sl = 8'd0; m.to = 1'b1; m.c0 = 1'b0; m.c1 = 1'b0; push();
        m.st = 3'd4; m.sl = 8'(R);
        m.win = (points0 > points1) ? 2'b01 : (points0 < points1) ? 2'b10 : 2'b11;
        push();
      end else begin
        s0 = (pf == due0) && !k0;
        s1 = (pf == due1) && !k1;
        if (pf % FPS == 0) m.sl = 8'(G - pf / FPS);
        m.sp0 = s0; m.sp1 = s1; push();
        m.sp0 = 1'b0; m.sp1 = 1'b0; push();
      end
    end else if (phase == 3) begin
      pf++;
      if (pf == FPS * R) begin
        phase = 0;
        m.st = 3'd0; m.sl = 8'(G); m.win = 2'b00; push();
      end else if (pf % FPS == 0) begin
        m.sl = 8'(R - pf / FPS); push();
      end
    end
    if (ph0 == 2 && phase == 2) begin
      if (k0) due0 = pf + RESP;
      if (k1) due1 = pf + RESP;
    end
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h", name, got, want);
    end
  endtask

  task automatic tick_frame(input bit k0, input bit k1);
    @(posedge clk); #2;
    vsync_in = 1'b1;
    frame_no++;
    if (k0) grem0_alive = 1'b0;
    if (k1) grem1_alive = 1'b0;
    model_frame(k0, k1);
    @(posedge clk); #2;
    grem0_alive = 1'b1;
    grem1_alive = 1'b1;
    @(posedge clk); #2;
    vsync_in = 1'b0;
    repeat ($urandom_range(3, 6)) @(posedge clk);
  endtask

  task automatic kill(input int i);
    @(posedge clk); #2;
    if (i == 0) grem0_alive = 1'b0;
    else        grem1_alive = 1'b0;
    model_kill(i);
    @(posedge clk); #2;
    grem0_alive = 1'b1;
    grem1_alive = 1'b1;
    @(posedge clk);
  endtask

  task automatic press_start();
    @(posedge clk); #2;
    start = 1'b1;
    model_start();
    repeat (2) @(posedge clk);
    #2 start = 1'b0;
    @(posedge clk);
  endtask

  task automatic run_round(input logic [7:0] p0, input logic [7:0] p1);
    points0 = p0;
    points1 = p1;
    press_start();
    for (int n = 0; n < 100 && phase != 0; n++) begin
      if ($urandom_range(0, 3) == 0) kill(int'($urandom_range(0, 1)));
      tick_frame($urandom_range(0, 4) == 0, $urandom_range(0, 4) == 0);
    end
  endtask

  task automatic check_outputs_reset(input string tag);
    check({tag, "_state"},   {29'd0, state_out}, 32'd0);
    check({tag, "_timeout"}, {31'd0, time_out}, 32'd1);
    check({tag, "_cars"},    {30'd0, car0_enable, car1_enable}, 32'd0);
    check({tag, "_spawns"},  {30'd0, grem0_spawn, grem1_spawn}, 32'd0);
    check({tag, "_clr_n"},   {31'd0, collision_rst_n}, 32'd1);
    check({tag, "_seconds"}, {24'd0, seconds_left}, G);
    check({tag, "_winner"},  {30'd0, winner}, 32'd0);
  endtask

  // Scoreboard monitor: every visible output change must match the next queued snapshot and frame.
  initial begin
    snap_t prev, cur;
    exp_t  e;
    prev = rst_snap();
    forever begin
      @(negedge clk);
      cur = dut_snap();
      if (cur !== prev) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_change got=%h at frame %0d, nothing queued", cur, frame_no);
        end else begin
          e = exp_q.pop_front();
          if (e.s !== cur || e.f != frame_no) begin
            failures++;
            $display("FAIL output_change got=%h frame %0d expected=%h frame %0d",
                     cur, frame_no, e.s, e.f);
          end
        end
        prev = cur;
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    m = rst_snap();
    last_pushed = m;
    rst = 1'b1; vsync_in = 1'b0; start = 1'b1;
    grem0_alive = 1'b1; grem1_alive = 1'b1;
    points0 = 8'd0; points1 = 8'd0;
`ifdef ROUND_CTRL_PAUSE_EN
    pause = 1'b0;
`endif
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;
    #1 check_outputs_reset("reset");

    // Button held from reset plus ten idle frames: nothing may happen.
    repeat (10) tick_frame(1'b0, 1'b0);
    check_outputs_reset("idle10");
    start = 1'b0;
    repeat (2) @(posedge clk);

    // Directed round: respawn timing, reload, late-start ignore, suppressed spawn, draw.
    points0 = 8'd5; points1 = 8'd5;
    press_start();
    repeat (FPS * CD) tick_frame(1'b0, 1'b0);
    kill(0);
    tick_frame(1'b0, 1'b0);
    press_start();
    tick_frame(1'b0, 1'b0);
    kill(0);
    tick_frame(1'b0, 1'b0);
    kill(0);
    tick_frame(1'b0, 1'b1);
    tick_frame(1'b0, 1'b0);
    tick_frame(1'b0, 1'b0);
    repeat (FPS * R) tick_frame(1'b0, 1'b0);

    run_round(8'd7, 8'd3);
    run_round(8'd0, 8'd9);
    for (int r = 0; r < 4; r++) begin
      logic [7:0] a, b;
      a = 8'($urandom_range(0, 255));
      b = ($urandom_range(0, 2) == 0) ? a : 8'($urandom_range(0, 255));
      run_round(a, b);
    end

    // Asynchronous reset mid-PLAY with the button held; replay needs a fresh edge.
    press_start();
    for (int n = 0; n < 50 && !(phase == 2 && pf >= 2); n++) tick_frame(1'b0, 1'b0);
    kill(1);
    @(posedge clk); #2;
    start = 1'b1;
    model_start();
    @(posedge clk); #2;
    rst = 1'b1;
    model_reset();
    #1 check_outputs_reset("midplay_rst");
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;
    repeat (4) tick_frame(1'b0, 1'b0);
    check_outputs_reset("after_rst");
    start = 1'b0;
    repeat (2) @(posedge clk);
    run_round(8'd200, 8'd199);

`ifdef ROUND_CTRL_PAUSE_EN
    points0 = 8'd1; points1 = 8'd2;
    press_start();
    repeat (FPS * CD) tick_frame(1'b0, 1'b0);
    kill(0);
    tick_frame(1'b0, 1'b0);
    @(posedge clk); #2;
    pause = 1'b1; pz = 1'b1;
    m.to = 1'b1; m.c0 = 1'b0; m.c1 = 1'b0; push();
    repeat (4 * FPS) tick_frame(1'b0, 1'b0);
    @(posedge clk); #2;
    pause = 1'b0; pz = 1'b0;
    m.to = 1'b0; m.c0 = 1'b1; m.c1 = 1'b1; push();
    for (int n = 0; n < 50 && phase != 0; n++) tick_frame(1'b0, 1'b0);
`endif

    repeat (20) @(posedge clk);
    check("scoreboard_drain", exp_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
